// File: rtl/shift_pkg.sv
// Definitions shared by the transmit and receive ends of the 194-style shift link:
// the frame direction codes and the frame-state encoding.
package shift_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } frame_state_t;

endpackage

// File: rtl/shift_rx_194_out_hold_reg.sv
// One-entry valid/ready holding register.
// A word that arrives while the entry is full and not being popped is dropped, and this sets a sticky overrun flag.
module out_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             overrun
);

    logic [WIDTH-1:0] q_reg;
    logic             valid_reg;
    logic             overrun_reg;
    logic             room;

    // A pop on the same edge frees the entry, so a push can still land.
    assign room = !valid_reg || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg       <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (push && room) begin
                q_reg     <= push_data;
                valid_reg <= 1'b1;
            end else if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end

            if (clr_overrun) begin
                overrun_reg <= 1'b0;
            end else if (push && !room) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign q       = q_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/shift_rx_194.sv
// Deserialiser for the serial stream that an HC_194-style shift register emits.
// It packs WIDTH bits, MSB-first or LSB-first, into one word and hands the word to a one-entry output buffer.
module shift_rx_194
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic             SerEn,
    input  logic             SerIn,
    input  logic             Dir,
    input  logic             Clr,
    output logic [WIDTH-1:0] Q,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Busy,
    output logic             Overrun
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    frame_state_t     state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             frame_dir_reg, frame_dir_next;
    logic             bit_dir;
    logic             push;
    logic [WIDTH-1:0] shl_word;
    logic [WIDTH-1:0] shr_word;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_place
            if (gi == 0) begin : g_shl_lsb
                assign shl_word[gi] = SerIn;
            end else begin : g_shl_mid
                assign shl_word[gi] = shift_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_shr_msb
                assign shr_word[gi] = SerIn;
            end else begin : g_shr_mid
                assign shr_word[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    // The first bit of a frame uses the live Dir; later bits use the direction latched for the frame.
    assign bit_dir = (state_reg == ST_IDLE) ? Dir : frame_dir_reg;

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        shift_next     = shift_reg;
        frame_dir_next = frame_dir_reg;
        push           = 1'b0;

        if (Clr) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else if (SerEn) begin
            if (state_reg == ST_IDLE) begin
                frame_dir_next = Dir;
            end
            shift_next = (bit_dir == DIR_LSB_FIRST) ? shr_word : shl_word;
            if (count_reg == LAST_COUNT) begin
                push       = 1'b1;
                count_next = '0;
                state_next = ST_IDLE;
            end else begin
                count_next = count_reg + CNT_W'(1);
                state_next = ST_SHIFT;
            end
        end
    end

    always_ff @(posedge Clk or posedge MR) begin
        if (MR) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            shift_reg     <= '0;
            frame_dir_reg <= DIR_MSB_FIRST;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            frame_dir_reg <= frame_dir_next;
        end
    end

    assign Busy = (state_reg == ST_SHIFT);

    out_hold_reg #(
        .WIDTH(WIDTH)
    ) u_out_hold (
        .clk        (Clk),
        .rst        (MR),
        .push       (push),
        .push_data  (shift_next),
        .ready      (OutReady),
        .clr_overrun(Clr),
        .q          (Q),
        .valid      (OutValid),
        .overrun    (Overrun)
    );

endmodule

// File: tb/tb_shift_rx_194.sv
// Testbench for shift_rx_194 with WIDTH=4. It runs directed scenarios and then random traffic.
// Every result is compared against a reference model that collects each frame's bits in a queue.
module tb_shift_rx_194;

    localparam int WIDTH = 4;

    logic             Clk = 1'b0;
    logic             MR, SerEn, SerIn, Dir, Clr, OutReady;
    logic [WIDTH-1:0] Q;
    logic             OutValid, Busy, Overrun;

    int checks = 0;
    int errors = 0;

    bit               m_bits[$];
    bit               m_dir;
    logic [WIDTH-1:0] m_q;
    bit               m_valid;
    bit               m_over;

    always #5 Clk = ~Clk;

    shift_rx_194 #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .MR      (MR),
        .SerEn   (SerEn),
        .SerIn   (SerIn),
        .Dir     (Dir),
        .Clr     (Clr),
        .Q       (Q),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .Busy    (Busy),
        .Overrun (Overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] assemble();
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (m_dir == 1'b0) w[WIDTH-1-i] = m_bits[i];
            else               w[i]         = m_bits[i];
        end
        return w;
    endfunction

    function automatic void model_reset();
        m_bits.delete();
        m_dir   = 1'b0;
        m_q     = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
    endfunction

    // Update the reference model for one rising edge, using the inputs held on that edge.
    function automatic void model_edge();
        bit               push;
        logic [WIDTH-1:0] word;
        push = 1'b0;
        word = '0;
        if (MR) begin
            model_reset();
            return;
        end
        if (Clr) begin
            m_bits.delete();
            m_over = 1'b0;
        end else if (SerEn) begin
            if (m_bits.size() == 0) m_dir = Dir;
            m_bits.push_back(SerIn);
            if (m_bits.size() == WIDTH) begin
                word = assemble();
                m_bits.delete();
                push = 1'b1;
            end
        end
        if (push) begin
            if (!m_valid || OutReady) begin
                $display("word %h dir=%0d loaded", word, m_dir);
                m_q     = word;
                m_valid = 1'b1;
            end else begin
                $display("word %h dir=%0d dropped", word, m_dir);
                m_over = 1'b1;
            end
        end else if (m_valid && OutReady) begin
            $display("word %h consumed", m_q);
            m_valid = 1'b0;
        end
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".Q"},        32'(Q),        32'(m_q));
        check({tag, ".OutValid"}, 32'(OutValid), 32'(m_valid));
        check({tag, ".Busy"},     32'(Busy),     32'(m_bits.size() != 0));
        check({tag, ".Overrun"},  32'(Overrun),  32'(m_over));
    endtask

    task automatic step(input bit en, input bit b, input bit d, input bit c, input bit rdy);
        SerEn    = en;
        SerIn    = b;
        Dir      = d;
        Clr      = c;
        OutReady = rdy;
        @(posedge Clk);
        model_edge();
        #1;
        compare_model("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        MR = 1'b1; SerEn = 1'b0; SerIn = 1'b0; Dir = 1'b0; Clr = 1'b0; OutReady = 1'b0;
        model_reset();
        #12;
        compare_model("reset");
        MR = 1'b0;

        // Dir=0, SerIn 1,0,1,1 on consecutive edges gives 4'b1011. Busy is 1 after edges 1 through 3.
        step(1, 1, 0, 0, 0); check("msb.busy1", 32'(Busy), 1);
        step(1, 0, 0, 0, 0); check("msb.busy2", 32'(Busy), 1);
        step(1, 1, 0, 0, 0); check("msb.busy3", 32'(Busy), 1);
        step(1, 1, 0, 0, 0);
        check("msb.q", 32'(Q), 32'(4'b1011));
        check("msb.valid", 32'(OutValid), 1);
        check("msb.busy4", 32'(Busy), 0);

        // Pop with no push clears OutValid and keeps Q.
        step(0, 0, 0, 0, 1);
        check("pop.valid", 32'(OutValid), 0);
        check("pop.q", 32'(Q), 32'(4'b1011));
        step(0, 0, 0, 0, 1);

        // Dir=1 with two-cycle gaps, and Dir toggled mid-frame, gives 4'b1101.
        step(1, 1, 1, 0, 0); idle(2);
        step(1, 0, 0, 0, 0); idle(2);
        step(1, 1, 0, 0, 0); idle(2);
        step(1, 1, 0, 0, 0);
        check("lsb.q", 32'(Q), 32'(4'b1101));
        check("lsb.valid", 32'(OutValid), 1);
        step(0, 0, 0, 0, 1);

        // Frames 4'hA and 4'h5 back to back with no reader: 4'h5 is dropped.
        // Frame 4'h3 then loads because OutReady is high on its last edge.
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
        check("ovr.q", 32'(Q), 32'hA);
        check("ovr.flag", 32'(Overrun), 1);
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 1);
        check("push_pop.q", 32'(Q), 32'h3);
        check("push_pop.valid", 32'(OutValid), 1);

        // Two bits, then Clr together with SerEn; the next four bits 1,1,1,0 give 4'b1110.
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        check("clr.busy", 32'(Busy), 0);
        check("clr.overrun", 32'(Overrun), 0);
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 1);
        check("clr.q", 32'(Q), 32'(4'b1110));

        // MR asserted mid-frame with OutValid=1 clears the outputs before the next clock edge.
        step(1, 1, 0, 0, 0);
        #2;
        MR = 1'b1;
        #1;
        check("mr.q", 32'(Q), 0);
        check("mr.valid", 32'(OutValid), 0);
        check("mr.busy", 32'(Busy), 0);
        check("mr.overrun", 32'(Overrun), 0);
        model_reset();
        step(1, 1, 0, 0, 0);
        MR = 1'b0;

        // Random traffic checked against the model.
        for (int i = 0; i < 1500; i++) begin
            MR = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 9) < 6, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 4);
            MR = 1'b0;
        end
        held = Q;
        idle(1);
        check("final.q_hold", 32'(Q), 32'(held));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
